// File: rtl/lpddr_burst_port_ctrl.sv
// Burst-request user-port controller for one MCB-style LPDDR port (write fill / read drain).
// Optional read-drain watchdog is compiled in with `define LPDDR_CTRL_WDOG_EN.

module lpddr_burst_port_ctrl #(
   parameter  int DATA_W         = 32,
   parameter  int MODE           = 2,
   parameter  bit AUTO_PRECHARGE = 1'b0,
   parameter  int WDOG_CYC       = 1023,
   localparam int MASK_W         = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [29:0]       req_addr,
   input  logic [5:0]        req_bl,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [DATA_W-1:0] wd_data,
   input  logic [MASK_W-1:0] wd_mask,
   output logic              rdo_valid,
   input  logic              rdo_ready,
   output logic [DATA_W-1:0] rdo_data,
   output logic              busy,
   output logic [3:0]        err,
   input  logic              err_clr,
   output logic              cmd_clk,
   output logic              cmd_en,
   output logic [2:0]        cmd_instr,
   output logic [5:0]        cmd_bl,
   output logic [29:0]       cmd_byte_addr,
   input  logic              cmd_full,
   output logic              wr_clk,
   output logic              wr_en,
   output logic [MASK_W-1:0] wr_mask,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_full,
   input  logic              wr_underrun,
   output logic              rd_clk,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_empty,
   input  logic              rd_overflow
);

   localparam int ADDR_SH = $clog2(MASK_W);
   localparam bit WR_OK   = (MODE != 1);
   localparam bit RD_OK   = (MODE != 0);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_FILL  = 3'd1,
      ST_WR_CMD   = 3'd2,
      ST_RD_CMD   = 3'd3,
      ST_RD_DRAIN = 3'd4,
      ST_ERR      = 3'd5
   } state_e;

   state_e      state_q;
   logic [5:0]  cnt_q;
   logic        cmd_en_q;
   logic [2:0]  cmd_instr_q;
   logic [5:0]  cmd_bl_q;
   logic [29:0] cmd_byte_addr_q;
   logic [3:0]  err_q;
   logic [3:0]  err_d;

   logic        req_hs_s;
   logic        illegal_s;
   logic        pop_s;
   logic        wdog_trip_s;
   logic [29:0] byte_addr_s;

   if (!(DATA_W == 32 || DATA_W == 64 || DATA_W == 128) || WDOG_CYC < 1) begin : g_param_check
      $error("lpddr_burst_port_ctrl: DATA_W must be 32/64/128 and WDOG_CYC >= 1");
   end

   // req_ready is held low while reset is asserted so nothing is taken during reset
   assign req_ready   = rst & (state_q == ST_IDLE);
   assign req_hs_s    = req_valid & req_ready;
   assign illegal_s   = req_hs_s & (req_wr ? !WR_OK : !RD_OK);
   assign byte_addr_s = req_addr << ADDR_SH;

   assign wd_ready  = (state_q == ST_WR_FILL) & ~wr_full;
   assign wr_en     = wd_valid & wd_ready;
   assign wr_data   = wd_data;
   assign wr_mask   = wd_mask;

   assign rdo_valid = (state_q == ST_RD_DRAIN) & ~rd_empty;
   assign rd_en     = rdo_valid & rdo_ready;
   assign pop_s     = rd_en;
   assign rdo_data  = rd_data;

   assign cmd_clk       = clk;
   assign wr_clk        = clk;
   assign rd_clk        = clk;
   assign cmd_en        = cmd_en_q;
   assign cmd_instr     = cmd_instr_q;
   assign cmd_bl        = cmd_bl_q;
   assign cmd_byte_addr = cmd_byte_addr_q;
   assign busy          = (state_q != ST_IDLE);
   assign err           = err_q;

`ifdef LPDDR_CTRL_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0] wdog_q;

   assign wdog_trip_s = (state_q == ST_RD_DRAIN) & ~pop_s & (wdog_q == WDOG_W'(WDOG_CYC - 1));

   // Counts consecutive pop-free cycles in RD_DRAIN; any pop or state exit restarts it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q <= {WDOG_W{1'b0}};
      end else if ((state_q == ST_RD_DRAIN) && !pop_s && !wdog_trip_s) begin
         wdog_q <= wdog_q + WDOG_W'(1);
      end else begin
         wdog_q <= {WDOG_W{1'b0}};
      end
   end
`else
   assign wdog_trip_s = 1'b0;
`endif

   // Sticky error merge; clear wins over any same-cycle set
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = 4'b0000;
      end else begin
         err_d[0] = err_q[0] | wr_underrun;
         err_d[1] = err_q[1] | rd_overflow;
         err_d[2] = err_q[2] | wdog_trip_s;
         err_d[3] = err_q[3] | illegal_s;
      end
   end

   // Control FSM with registered command-port outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= 6'd0;
         cmd_en_q        <= 1'b0;
         cmd_instr_q     <= 3'b000;
         cmd_bl_q        <= 6'd0;
         cmd_byte_addr_q <= 30'd0;
         err_q           <= 4'b0000;
      end else begin
         cmd_en_q <= 1'b0;
         err_q    <= err_d;
         case (state_q)
            ST_IDLE: begin
               if (req_hs_s && !illegal_s) begin
                  cnt_q           <= 6'd0;
                  cmd_bl_q        <= req_bl;
                  cmd_byte_addr_q <= byte_addr_s;
                  cmd_instr_q     <= {1'b0, AUTO_PRECHARGE, ~req_wr};
                  state_q         <= req_wr ? ST_WR_FILL : ST_RD_CMD;
               end
            end
            ST_WR_FILL: begin
               if (wr_en) begin
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == cmd_bl_q) begin
                     state_q <= ST_WR_CMD;
                  end
               end
            end
            ST_WR_CMD: begin
               if (!cmd_full) begin
                  cmd_en_q <= 1'b1;
                  state_q  <= ST_IDLE;
               end
            end
            ST_RD_CMD: begin
               if (!cmd_full) begin
                  cmd_en_q <= 1'b1;
                  cnt_q    <= 6'd0;
                  state_q  <= ST_RD_DRAIN;
               end
            end
            ST_RD_DRAIN: begin
               if (pop_s) begin
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == cmd_bl_q) begin
                     state_q <= ST_IDLE;
                  end
               end else if (wdog_trip_s) begin
                  state_q <= ST_ERR;
               end
            end
            ST_ERR: begin
               if (err_clr) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpddr_burst_port_ctrl.sv
// Randomised self-checking bench for lpddr_burst_port_ctrl: a 32-bit read/write port
// plus a 64-bit write-only port with auto-precharge for direction and field checks.

module tb_lpddr_burst_port_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid, req_wr;
   logic [29:0] req_addr;
   logic [5:0]  req_bl;
   logic        wd_valid, rdo_ready, err_clr, cmd_full, wr_full, wr_underrun, rd_empty, rd_overflow;
   logic [31:0] wd_data, rd_data;
   logic [3:0]  wd_mask;

   logic        req_ready, wd_ready, rdo_valid, busy, cmd_clk, cmd_en, wr_clk, wr_en, rd_clk, rd_en;
   logic [31:0] rdo_data, wr_data;
   logic [3:0]  err, wr_mask;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;

   logic        b_req_valid, b_err_clr;
   logic [63:0] b_wd_data, b_rd_data;
   logic [7:0]  b_wd_mask;
   logic        b_req_ready, b_wd_ready, b_rdo_valid, b_busy, b_cmd_clk, b_cmd_en, b_wr_clk, b_wr_en, b_rd_clk, b_rd_en;
   logic [63:0] b_rdo_data, b_wr_data;
   logic [7:0]  b_wr_mask;
   logic [3:0]  b_err;
   logic [2:0]  b_cmd_instr;
   logic [5:0]  b_cmd_bl;
   logic [29:0] b_cmd_byte_addr;

   int checks_cnt = 0;
   int errors_cnt = 0;

   lpddr_burst_port_ctrl u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_bl(req_bl), .wd_valid(wd_valid), .wd_ready(wd_ready),
      .wd_data(wd_data), .wd_mask(wd_mask), .rdo_valid(rdo_valid), .rdo_ready(rdo_ready),
      .rdo_data(rdo_data), .busy(busy), .err(err), .err_clr(err_clr), .cmd_clk(cmd_clk),
      .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
      .cmd_full(cmd_full), .wr_clk(wr_clk), .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data),
      .wr_full(wr_full), .wr_underrun(wr_underrun), .rd_clk(rd_clk), .rd_en(rd_en),
      .rd_data(rd_data), .rd_empty(rd_empty), .rd_overflow(rd_overflow)
   );

   lpddr_burst_port_ctrl #(.DATA_W(64), .MODE(0), .AUTO_PRECHARGE(1'b1)) u_dut_wo (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_bl(req_bl), .wd_valid(wd_valid), .wd_ready(b_wd_ready),
      .wd_data(b_wd_data), .wd_mask(b_wd_mask), .rdo_valid(b_rdo_valid), .rdo_ready(rdo_ready),
      .rdo_data(b_rdo_data), .busy(b_busy), .err(b_err), .err_clr(b_err_clr), .cmd_clk(b_cmd_clk),
      .cmd_en(b_cmd_en), .cmd_instr(b_cmd_instr), .cmd_bl(b_cmd_bl), .cmd_byte_addr(b_cmd_byte_addr),
      .cmd_full(cmd_full), .wr_clk(b_wr_clk), .wr_en(b_wr_en), .wr_mask(b_wr_mask), .wr_data(b_wr_data),
      .wr_full(wr_full), .wr_underrun(1'b0), .rd_clk(b_rd_clk), .rd_en(b_rd_en),
      .rd_data(b_rd_data), .rd_empty(rd_empty), .rd_overflow(1'b0)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         errors_cnt++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every task starts and ends just after a rising edge.
   task automatic do_write(input logic [29:0] addr, input logic [5:0] bl, input int stall);
      int acc;
      logic [29:0] exp_ba;
      exp_ba = 30'(addr * 30'd4);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_bl = bl;
      @(negedge clk);
      check_eq("wr_req_ready", req_ready, 1'b1);
      check_eq("wr_cmd_quiet", cmd_en, 1'b0);
      tick();
      req_valid = 1'b0; req_addr = 30'($urandom); req_bl = 6'($urandom);
      acc = 0;
      for (int c = 0; c < 600 && acc <= int'(bl); c++) begin
         wd_valid = ($urandom_range(0, 3) != 0);
         wd_data  = $urandom;
         wd_mask  = 4'($urandom);
         wr_full  = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         check_eq("wd_ready", wd_ready, !wr_full);
         check_eq("wr_en", wr_en, wd_valid & !wr_full);
         check_eq("fill_req_ready", req_ready, 1'b0);
         check_eq("fill_cmd_en", cmd_en, 1'b0);
         if (wd_valid && !wr_full) begin
            check_eq("wr_data", wr_data, wd_data);
            check_eq("wr_mask", wr_mask, wd_mask);
            acc++;
         end
         tick();
      end
      check_eq("wr_words", acc, int'(bl) + 1);
      wd_valid = 1'b1; wr_full = 1'b0;
      for (int s = 0; s < stall; s++) begin
         cmd_full = 1'b1;
         @(negedge clk);
         check_eq("stall_cmd_en", cmd_en, 1'b0);
         check_eq("stall_wr_en", wr_en, 1'b0);
         check_eq("stall_busy", busy, 1'b1);
         tick();
      end
      cmd_full = 1'b0;
      @(negedge clk);
      check_eq("wr_cmd_early", cmd_en, 1'b0);
      check_eq("wr_cmd_req_ready", req_ready, 1'b0);
      tick();
      wd_valid = 1'b0;
      cmd_full = 1'($urandom);
      @(negedge clk);
      check_eq("wr_cmd_en", cmd_en, 1'b1);
      check_eq("wr_cmd_instr", cmd_instr, 3'b000);
      check_eq("wr_cmd_bl", cmd_bl, bl);
      check_eq("wr_cmd_addr", cmd_byte_addr, exp_ba);
      check_eq("wr_done_ready", req_ready, 1'b1);
      check_eq("wr_done_busy", busy, 1'b0);
      tick();
      cmd_full = 1'b0;
      @(negedge clk);
      check_eq("wr_cmd_single", cmd_en, 1'b0);
      tick();
   endtask

   task automatic do_read(input logic [29:0] addr, input logic [5:0] bl, input int stall);
      logic [31:0] words [0:63];
      logic [29:0] exp_ba;
      int pidx;
      bit first;
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      exp_ba = 30'(addr * 30'd4);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_bl = bl;
      rd_empty = 1'b0; rdo_ready = 1'b1;
      @(negedge clk);
      check_eq("rd_req_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0; req_addr = 30'($urandom); req_bl = 6'($urandom);
      for (int s = 0; s < stall; s++) begin
         cmd_full = 1'b1;
         @(negedge clk);
         check_eq("rd_stall_cmd_en", cmd_en, 1'b0);
         check_eq("rd_stall_rdo_valid", rdo_valid, 1'b0);
         check_eq("rd_stall_rd_en", rd_en, 1'b0);
         tick();
      end
      cmd_full = 1'b0;
      @(negedge clk);
      check_eq("rd_cmd_early", cmd_en, 1'b0);
      check_eq("rd_cmd_rdo_valid", rdo_valid, 1'b0);
      tick();
      pidx = 0;
      first = 1'b1;
      for (int c = 0; c < 800 && pidx <= int'(bl); c++) begin
         rd_empty  = ($urandom_range(0, 2) == 0);
         rd_data   = rd_empty ? $urandom : words[pidx];
         rdo_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (first) begin
            check_eq("rd_cmd_en", cmd_en, 1'b1);
            check_eq("rd_cmd_instr", cmd_instr, 3'b001);
            check_eq("rd_cmd_bl", cmd_bl, bl);
            check_eq("rd_cmd_addr", cmd_byte_addr, exp_ba);
            first = 1'b0;
         end else begin
            check_eq("rd_cmd_single", cmd_en, 1'b0);
         end
         check_eq("rdo_valid", rdo_valid, !rd_empty);
         check_eq("rd_en", rd_en, !rd_empty & rdo_ready);
         check_eq("drain_req_ready", req_ready, 1'b0);
         if (!rd_empty && rdo_ready) begin
            check_eq("rdo_data", rdo_data, words[pidx]);
            pidx++;
         end
         tick();
      end
      check_eq("rd_words", pidx, int'(bl) + 1);
      rd_empty = 1'b0; rdo_ready = 1'b1;
      @(negedge clk);
      check_eq("rd_done_valid", rdo_valid, 1'b0);
      check_eq("rd_done_rd_en", rd_en, 1'b0);
      check_eq("rd_done_ready", req_ready, 1'b1);
      check_eq("rd_done_busy", busy, 1'b0);
      tick();
   endtask

   task automatic do_errors();
      wr_underrun = 1'b1;
      @(negedge clk);
      check_eq("err_not_yet", err, 4'b0000);
      tick();
      wr_underrun = 1'b0;
      @(negedge clk);
      check_eq("err_underrun", err, 4'b0001);
      rd_overflow = 1'b1; err_clr = 1'b1;
      tick();
      rd_overflow = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      check_eq("err_clr_priority", err, 4'b0000);
      rd_overflow = 1'b1;
      tick();
      rd_overflow = 1'b0;
      @(negedge clk);
      check_eq("err_overflow", err, 4'b0010);
      check_eq("err_nonblocking", req_ready, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check_eq("err_cleared", err, 4'b0000);
      tick();
   endtask

   task automatic do_reset_midfill();
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 30'h1234567; req_bl = 6'd3;
      tick();
      req_valid = 1'b0;
      wd_valid = 1'b1; wr_full = 1'b0; wr_underrun = 1'b1;
      tick();
      wr_underrun = 1'b0;
      tick();
      @(negedge clk);
      check_eq("pre_rst_busy", busy, 1'b1);
      check_eq("pre_rst_err", err, 4'b0001);
      tick();
      rst = 1'b0;
      #2;
      check_eq("rst_wd_ready", wd_ready, 1'b0);
      check_eq("rst_wr_en", wr_en, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_cmd", {cmd_en, cmd_bl, cmd_byte_addr}, 37'd0);
      check_eq("rst_err", err, 4'b0000);
      check_eq("rst_req_ready", req_ready, 1'b0);
      wd_valid = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_eq("post_rst_ready", req_ready, 1'b1);
      tick();
   endtask

   task automatic do_write_only_port();
      b_req_valid = 1'b1; req_wr = 1'b0; req_addr = 30'h10; req_bl = 6'd0;
      @(negedge clk);
      check_eq("wo_req_ready", b_req_ready, 1'b1);
      tick();
      b_req_valid = 1'b0;
      @(negedge clk);
      check_eq("wo_illegal_err", b_err, 4'b1000);
      check_eq("wo_illegal_idle", {b_busy, b_cmd_en, b_req_ready}, 3'b001);
      check_eq("wo_main_untouched", {busy, err}, 5'd0);
      b_req_valid = 1'b1; req_wr = 1'b1; req_bl = 6'd1;
      wd_valid = 1'b1; wr_full = 1'b0; cmd_full = 1'b0;
      tick();
      b_req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         b_wd_data = {$urandom, $urandom};
         b_wd_mask = 8'($urandom);
         @(negedge clk);
         check_eq("wo_wr_en", {b_wd_ready, b_wr_en}, 2'b11);
         check_eq("wo_wr_data", b_wr_data, b_wd_data);
         check_eq("wo_wr_mask", b_wr_mask, b_wd_mask);
         tick();
      end
      wd_valid = 1'b0;
      @(negedge clk);
      check_eq("wo_cmd_early", b_cmd_en, 1'b0);
      tick();
      b_rd_data = {$urandom, $urandom};
      @(negedge clk);
      check_eq("wo_cmd_en", b_cmd_en, 1'b1);
      check_eq("wo_cmd_instr", b_cmd_instr, 3'b010);
      check_eq("wo_cmd_bl", b_cmd_bl, 6'd1);
      check_eq("wo_cmd_addr", b_cmd_byte_addr, 30'h80);
      check_eq("wo_err_sticky", b_err, 4'b1000);
      check_eq("wo_rd_idle", {b_rdo_valid, b_rd_en}, 2'b00);
      check_eq("wo_rdo_data", b_rdo_data, b_rd_data);
      check_eq("clk_fwd", {cmd_clk, wr_clk, rd_clk, b_cmd_clk, b_wr_clk, b_rd_clk}, {6{clk}});
      b_err_clr = 1'b1;
      tick();
      b_err_clr = 1'b0;
      @(negedge clk);
      check_eq("wo_err_clr", b_err, 4'b0000);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_wr = 1'b0; req_addr = 30'd0; req_bl = 6'd0;
      wd_valid = 1'b0; wd_data = 32'd0; wd_mask = 4'd0; rdo_ready = 1'b0; err_clr = 1'b0;
      cmd_full = 1'b0; wr_full = 1'b0; wr_underrun = 1'b0; rd_data = 32'd0; rd_empty = 1'b1;
      rd_overflow = 1'b0;
      b_req_valid = 1'b0; b_err_clr = 1'b0; b_wd_data = 64'd0; b_wd_mask = 8'd0; b_rd_data = 64'd0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_outputs", {cmd_en, cmd_bl, cmd_byte_addr, err, busy}, 42'd0);
      check_eq("reset_req_ready", req_ready, 1'b0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_eq("release_req_ready", req_ready, 1'b1);
      tick();

      do_write(30'h100, 6'd3, 0);
      do_write(30'h100, 6'd3, 5);
      do_read(30'h10, 6'd7, 2);
      do_write(30'h3FFF_FFFF, 6'd0, 1);
      do_read(30'h3FFF_FFF0, 6'd63, 0);
      do_errors();
      do_reset_midfill();
      do_write(30'h2A, 6'd3, 0);
      do_write_only_port();
      for (int t = 0; t < 24; t++) begin
         logic [5:0] bl;
         bl = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            do_write(30'($urandom), bl, $urandom_range(0, 5));
         else
            do_read(30'($urandom), bl, $urandom_range(0, 5));
      end
      @(negedge clk);
      check_eq("final_err", err, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
